// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard control unit: FSM encoding and register-file constants.
// Pure declarations; no timing or flow-control behaviour of its own.
package hazard_control_unit_pkg;

    localparam int REG_W = 4;

    // R0 is hardwired to zero, so it never participates in forwarding or load-use detection.
    localparam logic [REG_W-1:0] R0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hcuState_e;

endpackage

// File: rtl/hazard_control_unit_fwd_compare.sv
// One operand's bypass select: EX/MEM (XX) beats MEM/WB (MX); R0 never matches.
// Purely combinational, zero latency; no flow control.
module fwd_compare
    import hazard_control_unit_pkg::*;
(
    input  logic [REG_W-1:0] srcReg,
    input  logic             srcUsed,
    input  logic [REG_W-1:0] exDst,
    input  logic             exRfWr,
    input  logic [REG_W-1:0] memDst,
    input  logic             memRfWr,
    output logic             xxFwd,
    output logic             mxFwd
);

    always_comb begin
        xxFwd = srcUsed && exRfWr && (exDst == srcReg) && (exDst != R0);
        mxFwd = srcUsed && memRfWr && (memDst == srcReg) && (memDst != R0) && !xxFwd;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline-register write enables, bubbles and forwarding flags; sequences stalls, flushes and halt drain.
// Controls are combinational from state + inputs (zero latency); halted/stall_count are registered.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic             id_hlt,
    input  logic             id_br_taken,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_rf_wr,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_rf_wr,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_noop,
    output logic             idex_we,
    output logic             idex_noop,
    output logic             exmem_we,
    output logic             memwb_noop,
    output logic             xx_reg1,
    output logic             xx_reg2,
    output logic             mx_reg1,
    output logic             mx_reg2,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRW-1:0] DRAIN_LOAD = DRW'(DRAIN_CYCLES - 1);

    hcuState_e      state, nextState;
    logic [DRW-1:0] drainCnt, drainNext;

    logic xx1Raw, xx2Raw, mx1Raw, mx2Raw;
    logic loadUse;

    fwd_compare u_fwd1 (
        .srcReg  (id_src1),
        .srcUsed (id_src1_used),
        .exDst   (ex_dst),
        .exRfWr  (ex_rf_wr),
        .memDst  (mem_dst),
        .memRfWr (mem_rf_wr),
        .xxFwd   (xx1Raw),
        .mxFwd   (mx1Raw)
    );

    fwd_compare u_fwd2 (
        .srcReg  (id_src2),
        .srcUsed (id_src2_used),
        .exDst   (ex_dst),
        .exRfWr  (ex_rf_wr),
        .memDst  (mem_dst),
        .memRfWr (mem_rf_wr),
        .xxFwd   (xx2Raw),
        .mxFwd   (mx2Raw)
    );

    always_comb begin
        xx_reg1 = xx1Raw && !rst;
        xx_reg2 = xx2Raw && !rst;
        mx_reg1 = mx1Raw && !rst;
        mx_reg2 = mx2Raw && !rst;
    end

    // A load result is only available after MEM, so forwarding cannot cover it next cycle.
    always_comb begin
        loadUse = ex_is_load && ex_rf_wr && (ex_dst != R0) &&
                  ((id_src1_used && (ex_dst == id_src1)) ||
                   (id_src2_used && (ex_dst == id_src2)));
    end

    always_comb begin
        nextState  = state;
        drainNext  = drainCnt;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_noop  = 1'b0;
        idex_we    = 1'b1;
        idex_noop  = 1'b0;
        exmem_we   = 1'b1;
        memwb_noop = 1'b0;

        unique case (state)
            // MEM_WAIT releases with no lost cycle: once memory is done the ID
            // instruction is evaluated exactly as in RUN.
            RUN, MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_we    = 1'b0;
                    exmem_we   = 1'b0;
                    memwb_noop = 1'b1;
                    nextState  = MEM_WAIT;
                end else begin
                    nextState = RUN;
                    if (loadUse) begin
                        pc_we     = 1'b0;
                        ifid_we   = 1'b0;
                        idex_noop = 1'b1;
                    end else if (id_br_taken) begin
                        ifid_noop = 1'b1;
                    end else if (id_hlt) begin
                        pc_we     = 1'b0;
                        ifid_noop = 1'b1;
                        drainNext = DRAIN_LOAD;
                        nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                pc_we     = 1'b0;
                ifid_noop = 1'b1;
                idex_noop = 1'b1;
                if (dmem_busy) begin
                    ifid_we    = 1'b0;
                    idex_we    = 1'b0;
                    exmem_we   = 1'b0;
                    memwb_noop = 1'b1;
                end else if (drainCnt == '0) begin
                    nextState = HALTED;
                end else begin
                    drainNext = drainCnt - 1'b1;
                end
            end
            HALTED: begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                ifid_noop  = 1'b1;
                idex_we    = 1'b0;
                idex_noop  = 1'b1;
                exmem_we   = 1'b0;
                memwb_noop = 1'b1;
            end
        endcase

        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_noop  = 1'b1;
            idex_we    = 1'b0;
            idex_noop  = 1'b1;
            exmem_we   = 1'b0;
            memwb_noop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            drainCnt    <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= nextState;
            drainCnt <= drainNext;
            halted   <= (nextState == HALTED);
            if (!pc_we && (state != HALTED) && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
